// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and NUM_SBOX legality helper for the
// S-box sharing controller.
package aes_pkg;

  localparam int unsigned AES_STATE_BYTES = 16;
  localparam int unsigned AES_WORD_BYTES  = 4;
  localparam int unsigned AES_STATE_W     = 8 * AES_STATE_BYTES;
  localparam int unsigned AES_WORD_W      = 8 * AES_WORD_BYTES;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_SUB  = 2'd1,
    FSM_KEY  = 2'd2
  } fsm_e;

  // Only lane counts that divide the state evenly and cover a full word.
  function automatic bit num_sbox_legal(input int unsigned n);
    return (n == 4) || (n == 8) || (n == 16);
  endfunction

endpackage

// File: rtl/aes_sbox_share_ctrl_if.sv
// Client handshakes plus the shared S-box lane bus.
interface aes_sbox_share_ctrl_if #(
  parameter int unsigned NUM_SBOX = 4
);
  import aes_pkg::*;

  localparam int unsigned LANE_W = 8 * NUM_SBOX;

  logic                   sb_req;
  logic [AES_STATE_W-1:0] sb_state_in;
  logic                   sb_ack;
  logic [AES_STATE_W-1:0] sb_state_out;
  logic                   kw_req;
  logic [AES_WORD_W-1:0]  kw_word_in;
  logic                   kw_ack;
  logic [AES_WORD_W-1:0]  kw_word_out;
  logic [LANE_W-1:0]      sbox_in;
  logic [LANE_W-1:0]      sbox_out;
  logic                   busy;

  // Clients and S-box bank side.
  modport master (
    output sb_req, sb_state_in, kw_req, kw_word_in, sbox_out,
    input  sb_ack, sb_state_out, kw_ack, kw_word_out, sbox_in, busy
  );

  // Controller side.
  modport slave (
    input  sb_req, sb_state_in, kw_req, kw_word_in, sbox_out,
    output sb_ack, sb_state_out, kw_ack, kw_word_out, sbox_in, busy
  );

endinterface

// File: rtl/aes_sbox_arb.sv
// Two-requester grant logic (SubBytes vs SubWord).
// SBOX_RR_ARB_EN defined: round-robin on ties; otherwise fixed kw-over-sb.
module aes_sbox_arb (
`ifdef SBOX_RR_ARB_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic sb_el,
  input  logic kw_el,
  output logic gnt_sb_c,
  output logic gnt_kw_c
);

`ifdef SBOX_RR_ARB_EN
  logic last_kw;

  // Tie goes to whichever client was not granted last.
  always_comb begin
    gnt_sb_c = 1'b0;
    gnt_kw_c = 1'b0;
    if (en) begin
      if (sb_el && kw_el) begin
        gnt_sb_c = last_kw;
        gnt_kw_c = ~last_kw;
      end else begin
        gnt_sb_c = sb_el;
        gnt_kw_c = kw_el;
      end
    end
  end

  // Remember last grant; resets to "kw" so the first tie favours sb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_kw <= 1'b1;
    end else if (gnt_sb_c || gnt_kw_c) begin
      last_kw <= gnt_kw_c;
    end
  end
`else
  // Key expansion always wins so it never stalls behind the datapath.
  always_comb begin
    gnt_kw_c = en & kw_el;
    gnt_sb_c = en & sb_el & ~kw_el;
  end
`endif

endmodule

// File: rtl/aes_sbox_share_ctrl.sv
// Time-shares NUM_SBOX external S-box lanes between SubBytes (128-bit state,
// 16/NUM_SBOX beats) and SubWord (32-bit word, one beat).
// Optional macro SBOX_RR_ARB_EN selects round-robin arbitration.
module aes_sbox_share_ctrl #(
  parameter int unsigned NUM_SBOX = 4
) (
  input logic                clk,
  input logic                rst,
  aes_sbox_share_ctrl_if.slave bus
);
  import aes_pkg::*;

  localparam int unsigned LANE_W    = 8 * NUM_SBOX;
  localparam int unsigned NUM_BEATS = AES_STATE_BYTES / NUM_SBOX;
  localparam int unsigned BEAT_W    = 4;

  localparam logic [1:0] ST_IDLE = FSM_IDLE;
  localparam logic [1:0] ST_SUB  = FSM_SUB;
  localparam logic [1:0] ST_KEY  = FSM_KEY;

  if (!num_sbox_legal(NUM_SBOX)) begin : g_num_sbox_check
    $error("aes_sbox_share_ctrl: NUM_SBOX must be 4, 8 or 16");
  end

  logic [1:0]             state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [AES_STATE_W-1:0] hold_q, hold_d;
  logic [LANE_W-1:0]      sbox_in_q, sbox_in_d;
  logic                   sb_ack_q, sb_ack_d;
  logic                   kw_ack_q, kw_ack_d;
  logic [AES_STATE_W-1:0] sb_out_q, sb_out_d;
  logic [AES_WORD_W-1:0]  kw_out_q, kw_out_d;
  logic                   busy_q, busy_d;
  logic [7:0]             slice_hi;
  logic [7:0]             slice_nx;
  logic                   gnt_sb, gnt_kw;

  aes_sbox_arb u_arb (
`ifdef SBOX_RR_ARB_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .en       (state_q == ST_IDLE),
    .sb_el    (bus.sb_req & ~sb_ack_q),
    .kw_el    (bus.kw_req & ~kw_ack_q),
    .gnt_sb_c (gnt_sb),
    .gnt_kw_c (gnt_kw)
  );

  // MSB index of the current beat's slice in the hold register.
  always_comb begin
    slice_hi = 8'(AES_STATE_W - 1 - LANE_W * 32'(beat_q));
    slice_nx = 8'(32'(slice_hi) - LANE_W);
  end

  // Next-state, lane feed and capture; hold doubles as result accumulator.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    hold_d    = hold_q;
    sbox_in_d = '0;
    sb_ack_d  = 1'b0;
    kw_ack_d  = 1'b0;
    sb_out_d  = sb_out_q;
    kw_out_d  = kw_out_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_kw) begin
          state_d = ST_KEY;
          beat_d  = '0;
          hold_d  = '0;
          hold_d[AES_STATE_W-1 -: AES_WORD_W]   = bus.kw_word_in;
          sbox_in_d[LANE_W-1 -: AES_WORD_W]     = bus.kw_word_in;
        end else if (gnt_sb) begin
          state_d   = ST_SUB;
          beat_d    = '0;
          hold_d    = bus.sb_state_in;
          sbox_in_d = bus.sb_state_in[AES_STATE_W-1 -: LANE_W];
        end
      end
      ST_SUB: begin
        hold_d[slice_hi -: LANE_W] = bus.sbox_out;
        if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
          sb_out_d = hold_d;
          sb_ack_d = 1'b1;
          state_d  = ST_IDLE;
          beat_d   = '0;
        end else begin
          beat_d    = beat_q + BEAT_W'(1);
          sbox_in_d = hold_q[slice_nx -: LANE_W];
        end
      end
      ST_KEY: begin
        kw_out_d = bus.sbox_out[LANE_W-1 -: AES_WORD_W];
        kw_ack_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any operation silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      hold_q    <= '0;
      sbox_in_q <= '0;
      sb_ack_q  <= 1'b0;
      kw_ack_q  <= 1'b0;
      sb_out_q  <= '0;
      kw_out_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      hold_q    <= hold_d;
      sbox_in_q <= sbox_in_d;
      sb_ack_q  <= sb_ack_d;
      kw_ack_q  <= kw_ack_d;
      sb_out_q  <= sb_out_d;
      kw_out_q  <= kw_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sb_ack       = sb_ack_q;
  assign bus.kw_ack       = kw_ack_q;
  assign bus.sb_state_out = sb_out_q;
  assign bus.kw_word_out  = kw_out_q;
  assign bus.sbox_in      = sbox_in_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_aes_sbox_share_ctrl.sv
// Self-checking bench for aes_sbox_share_ctrl with a behavioural S-box bank.
module tb_aes_sbox_share_ctrl #(
  parameter int unsigned NUM_SBOX = 4
);
  localparam int unsigned LANE_W = 8 * NUM_SBOX;
  localparam int unsigned NB     = 16 / NUM_SBOX;
`ifdef SBOX_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [127:0] ST_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ST_AX = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ST_F  = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] ST_FX = 128'h16161616161616161616161616161616;
  localparam logic [31:0]  KW_A  = 32'hcf4f3c09;
  localparam logic [31:0]  KW_AX = 32'h8a84eb01;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  aes_sbox_share_ctrl_if #(.NUM_SBOX(NUM_SBOX)) bus ();

  aes_sbox_share_ctrl #(.NUM_SBOX(NUM_SBOX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r, e;
    r = 8'h01; e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
    assign bus.sbox_out[LANE_W-1-8*i -: 8] = sbox_f(bus.sbox_in[LANE_W-1-8*i -: 8]);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SubBytes transaction; req dropped in the ack cycle.
  task automatic sb_op(input logic [127:0] din, output int lat, output logic [127:0] dout,
                       output logic busy1);
    bus.sb_state_in = din;
    bus.sb_req = 1'b1;
    lat = 0;
    busy1 = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) busy1 = bus.busy;
    end while (!bus.sb_ack && lat < 64);
    dout = bus.sb_state_out;
    bus.sb_req = 1'b0;
  endtask

  // One SubWord transaction; also grabs the lane bus during the beat.
  task automatic kw_op(input logic [31:0] din, output int lat, output logic [31:0] dout,
                       output logic [LANE_W-1:0] lanes);
    bus.kw_word_in = din;
    bus.kw_req = 1'b1;
    lat = 0;
    lanes = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) lanes = bus.sbox_in;
    end while (!bus.kw_ack && lat < 64);
    dout = bus.kw_word_out;
    bus.kw_req = 1'b0;
  endtask

  // Both clients request together; reports who finished first and both latencies.
  task automatic tie_op(output logic first_kw, output int lat1, output int lat2,
                        output logic busy_ack);
    bus.sb_state_in = ST_A;
    bus.kw_word_in  = KW_A;
    bus.sb_req = 1'b1;
    bus.kw_req = 1'b1;
    lat1 = 0;
    do begin
      @(negedge clk);
      lat1++;
    end while (!bus.sb_ack && !bus.kw_ack && lat1 < 64);
    first_kw = bus.kw_ack;
    busy_ack = bus.busy;
    if (first_kw) bus.kw_req = 1'b0;
    else          bus.sb_req = 1'b0;
    lat2 = 0;
    do begin
      @(negedge clk);
      lat2++;
    end while (!(first_kw ? bus.sb_ack : bus.kw_ack) && lat2 < 64);
    bus.sb_req = 1'b0;
    bus.kw_req = 1'b0;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } sb_vec_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } kw_vec_t;

  initial begin
    sb_vec_t            sb_tab[3];
    kw_vec_t            kw_tab[3];
    int                 lat, lat2;
    logic [127:0]       d128;
    logic [31:0]        d32;
    logic [LANE_W-1:0]  lanes, exp_lanes;
    logic               b1, first_kw;

    sb_tab[0] = '{din: ST_A,   dout: ST_AX};
    sb_tab[1] = '{din: 128'h0, dout: 128'h63636363636363636363636363636363};
    sb_tab[2] = '{din: ST_F,   dout: ST_FX};
    kw_tab[0] = '{din: KW_A,         dout: KW_AX};
    kw_tab[1] = '{din: 32'h00000000, dout: 32'h63636363};
    kw_tab[2] = '{din: 32'h6c76052a, dout: 32'h50386be5};

    rst = 1'b1;
    bus.sb_req = 1'b0;
    bus.kw_req = 1'b0;
    bus.sb_state_in = '0;
    bus.kw_word_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_sb_ack",  128'(bus.sb_ack), 128'(0));
    chk("rst_kw_ack",  128'(bus.kw_ack), 128'(0));
    chk("rst_busy",    128'(bus.busy), 128'(0));
    chk("rst_sb_out",  bus.sb_state_out, 128'(0));
    chk("rst_kw_out",  128'(bus.kw_word_out), 128'(0));
    chk("rst_sbox_in", 128'(bus.sbox_in), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      sb_op(sb_tab[i].din, lat, d128, b1);
      chk($sformatf("sb_lat[%0d]", i), 128'(lat), 128'(NB + 1));
      chk($sformatf("sb_data[%0d]", i), d128, sb_tab[i].dout);
      chk($sformatf("sb_busy[%0d]", i), 128'(b1), 128'(1));
      @(negedge clk);
      chk($sformatf("sb_ack_pulse[%0d]", i), 128'(bus.sb_ack), 128'(0));
      chk($sformatf("sb_idle[%0d]", i), 128'(bus.busy), 128'(0));
    end

    for (int i = 0; i < 3; i++) begin
      kw_op(kw_tab[i].din, lat, d32, lanes);
      exp_lanes = '0;
      exp_lanes[LANE_W-1 -: 32] = kw_tab[i].din;
      chk($sformatf("kw_lat[%0d]", i), 128'(lat), 128'(2));
      chk($sformatf("kw_data[%0d]", i), 128'(d32), 128'(kw_tab[i].dout));
      chk($sformatf("kw_lanes[%0d]", i), 128'(lanes), 128'(exp_lanes));
      @(negedge clk);
      chk($sformatf("kw_ack_pulse[%0d]", i), 128'(bus.kw_ack), 128'(0));
    end

    // Simultaneous requests, twice: order fixed by policy, no bubble between.
    for (int t = 0; t < 2; t++) begin
      tie_op(first_kw, lat, lat2, b1);
      chk($sformatf("tie_first_kw[%0d]", t), 128'(first_kw), 128'(!RR));
      chk($sformatf("tie_lat1[%0d]", t), 128'(lat), 128'(RR ? NB + 1 : 2));
      chk($sformatf("tie_lat2[%0d]", t), 128'(lat2), 128'(RR ? 2 : NB + 1));
      chk($sformatf("tie_ack_idle[%0d]", t), 128'(b1), 128'(0));
      chk($sformatf("tie_sb_data[%0d]", t), bus.sb_state_out, ST_AX);
      chk($sformatf("tie_kw_data[%0d]", t), 128'(bus.kw_word_out), 128'(KW_AX));
      @(negedge clk);
    end

    // Input changed mid-operation is ignored; held req re-grants one cycle after ack.
    bus.sb_state_in = ST_A;
    bus.sb_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.sb_state_in = ST_F;
    end while (!bus.sb_ack && lat < 64);
    chk("held_lat1", 128'(lat), 128'(NB + 1));
    chk("held_data1", bus.sb_state_out, ST_AX);
    @(negedge clk);
    chk("held_no_regrant", 128'(bus.busy), 128'(0));
    chk("held_ack_low", 128'(bus.sb_ack), 128'(0));
    @(negedge clk);
    chk("held_regrant", 128'(bus.busy), 128'(1));
    lat = 2;
    while (!bus.sb_ack && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("held_lat2", 128'(lat), 128'(NB + 2));
    chk("held_data2", bus.sb_state_out, ST_FX);
    bus.sb_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of SUB: no ack, outputs cleared, held req re-runs.
    bus.sb_state_in = ST_A;
    bus.sb_req = 1'b1;
    repeat ((NB > 2) ? 3 : 1) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack",     128'(bus.sb_ack), 128'(0));
    chk("mid_rst_busy",    128'(bus.busy), 128'(0));
    chk("mid_rst_sb_out",  bus.sb_state_out, 128'(0));
    chk("mid_rst_kw_out",  128'(bus.kw_word_out), 128'(0));
    chk("mid_rst_sbox_in", 128'(bus.sbox_in), 128'(0));
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_hold_ack", 128'(bus.sb_ack), 128'(0));
    end
    rst = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.sb_ack && lat < 64);
    chk("post_rst_lat", 128'(lat), 128'(NB + 1));
    chk("post_rst_data", bus.sb_state_out, ST_AX);
    bus.sb_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
